cpu_alu_muldiv: RTL and testbench

Integer arithmetic core of the RV32 execute stage. It contains three units. A combinational ALU handles add/sub, logic, shifts and compares for arithmetic, address, jump and branch evaluation. A pipelined 32×32→64 multiplier and a pipelined 32/32 divider serve the M-extension. The execute stage holds operands stable and counts cycles to collect the multiply and divide results.

---
 rtl/cpu_alu_muldiv.sv | 149 ++++++++++++++
 tb/tb_cpu_alu_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_muldiv.sv
// RV32 execute-stage integer core: combinational ALU, 2-cycle 32x32->64 multiplier,
// 3-cycle 32/32 restoring divider. No handshakes; the consumer counts cycles.
module cpu_alu_muldiv (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_alu_op1,
  input  logic [31:0] i_alu_op2,
  output logic [31:0] o_alu_result,
  output logic        o_alu_compare,
  input  logic        i_mul_signed,
  input  logic [31:0] i_mul_op1,
  input  logic [31:0] i_mul_op2,
  output logic [63:0] o_mul_result,
  input  logic        i_div_signed,
  input  logic [31:0] i_div_numerator,
  input  logic [31:0] i_div_denominator,
  output logic [31:0] o_div_result,
  output logic [31:0] o_div_remainder
);

  // ---------------- ALU ----------------
  logic [4:0] shamt;
  assign shamt = i_alu_op2[4:0];

  always_comb begin
    o_alu_result  = '0;
    o_alu_compare = 1'b0;
    case (i_alu_op)
      4'd0:  o_alu_result = i_alu_op1 + i_alu_op2;
      4'd1:  o_alu_result = i_alu_op1 - i_alu_op2;
      4'd2:  o_alu_result = i_alu_op1 & i_alu_op2;
      4'd3:  o_alu_result = i_alu_op1 | i_alu_op2;
      4'd4:  o_alu_result = i_alu_op1 ^ i_alu_op2;
      4'd5:  o_alu_result = i_alu_op1 << shamt;
      4'd6:  o_alu_result = i_alu_op1 >> shamt;
      4'd7:  o_alu_result = $unsigned($signed(i_alu_op1) >>> shamt);
      4'd8:  o_alu_compare = (i_alu_op1 == i_alu_op2);
      4'd9:  o_alu_compare = (i_alu_op1 != i_alu_op2);
      4'd10: o_alu_compare = ($signed(i_alu_op1) <  $signed(i_alu_op2));
      4'd11: o_alu_compare = (i_alu_op1 <  i_alu_op2);
      4'd12: o_alu_compare = ($signed(i_alu_op1) >= $signed(i_alu_op2));
      4'd13: o_alu_compare = (i_alu_op1 >= i_alu_op2);
      default: ;
    endcase
    if (i_alu_op >= 4'd8 && i_alu_op <= 4'd13)
      o_alu_result = {31'b0, o_alu_compare};
  end

  // ---------------- Multiplier ----------------
  logic [31:0] mul_a_q, mul_b_q;
  logic        mul_s_q;
  logic [63:0] mul_p_q, mul_p_d;
  logic [63:0] mul_ea, mul_eb;

  // Sign-extend to 64 bits; the low 64 bits of the product are exact either way.
  always_comb begin
    mul_ea  = {{32{mul_s_q & mul_a_q[31]}}, mul_a_q};
    mul_eb  = {{32{mul_s_q & mul_b_q[31]}}, mul_b_q};
    mul_p_d = mul_ea * mul_eb;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      mul_s_q <= 1'b0;
      mul_p_q <= '0;
    end else begin
      mul_a_q <= i_mul_op1;
      mul_b_q <= i_mul_op2;
      mul_s_q <= i_mul_signed;
      mul_p_q <= mul_p_d;
    end
  end

  assign o_mul_result = mul_p_q;

  // ---------------- Divider ----------------
  // Stage 1: magnitudes and sign/special flags
  logic [31:0] dn_mag_d, dd_mag_d, dn_mag_q, dd_mag_q;
  logic        qneg_d, rneg_d, dz_d, ovf_d;
  logic        qneg_q, rneg_q, dz_q, ovf_q;

  always_comb begin
    rneg_d   = i_div_signed & i_div_numerator[31];
    qneg_d   = i_div_signed & (i_div_numerator[31] ^ i_div_denominator[31]);
    dn_mag_d = rneg_d ? -i_div_numerator : i_div_numerator;
    dd_mag_d = (i_div_signed & i_div_denominator[31]) ? -i_div_denominator
                                                      : i_div_denominator;
    dz_d     = (i_div_denominator == 32'd0);
    ovf_d    = i_div_signed && (i_div_numerator == 32'h8000_0000) &&
               (i_div_denominator == 32'hFFFF_FFFF);
  end

  // Stage 2: unsigned restoring divide
  logic [31:0] q2_d, r2_d, q2_q, r2_q;
  logic        qneg2_q, rneg2_q, dz2_q, ovf2_q;
  logic [32:0] trial;

  always_comb begin
    q2_d  = '0;
    r2_d  = '0;
    trial = '0;
    for (int i = 31; i >= 0; i--) begin
      trial = {r2_d, dn_mag_q[i]};
      if (trial >= {1'b0, dd_mag_q}) begin
        trial   = trial - {1'b0, dd_mag_q};
        q2_d[i] = 1'b1;
      end
      r2_d = trial[31:0];
    end
    // Zero divisor: quotient is overridden later; zeroing it keeps a flushed pipe at 0.
    if (dd_mag_q == 32'd0) q2_d = '0;
  end

  // Stage 3: sign correction and special cases
  logic [31:0] q3_d, r3_d, q3_q, r3_q;

  always_comb begin
    q3_d = qneg2_q ? -q2_q : q2_q;
    r3_d = rneg2_q ? -r2_q : r2_q;
    if (dz2_q) q3_d = 32'hFFFF_FFFF;
    if (ovf2_q) begin
      q3_d = 32'h8000_0000;
      r3_d = 32'd0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      dn_mag_q <= '0; dd_mag_q <= '0;
      qneg_q   <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
      q2_q     <= '0; r2_q <= '0;
      qneg2_q  <= 1'b0; rneg2_q <= 1'b0; dz2_q <= 1'b0; ovf2_q <= 1'b0;
      q3_q     <= '0; r3_q <= '0;
    end else begin
      dn_mag_q <= dn_mag_d; dd_mag_q <= dd_mag_d;
      qneg_q   <= qneg_d; rneg_q <= rneg_d; dz_q <= dz_d; ovf_q <= ovf_d;
      q2_q     <= q2_d; r2_q <= r2_d;
      qneg2_q  <= qneg_q; rneg2_q <= rneg_q; dz2_q <= dz_q; ovf2_q <= ovf_q;
      q3_q     <= q3_d; r3_q <= r3_d;
    end
  end

  assign o_div_result    = q3_q;
  assign o_div_remainder = r3_q;

endmodule

// File: tb/tb_cpu_alu_muldiv.sv
// Directed + scoreboarded bench for cpu_alu_muldiv: ALU sweep, mul/div latency,
// divide corner cases, back-to-back issue and mid-stream reset.
module tb_cpu_alu_muldiv;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [3:0]  i_alu_op;
  logic [31:0] i_alu_op1, i_alu_op2, o_alu_result;
  logic        o_alu_compare;
  logic        i_mul_signed;
  logic [31:0] i_mul_op1, i_mul_op2;
  logic [63:0] o_mul_result;
  logic        i_div_signed;
  logic [31:0] i_div_numerator, i_div_denominator, o_div_result, o_div_remainder;

  always #5 i_clock = ~i_clock;

  cpu_alu_muldiv dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_alu_op(i_alu_op), .i_alu_op1(i_alu_op1), .i_alu_op2(i_alu_op2),
    .o_alu_result(o_alu_result), .o_alu_compare(o_alu_compare),
    .i_mul_signed(i_mul_signed), .i_mul_op1(i_mul_op1), .i_mul_op2(i_mul_op2),
    .o_mul_result(o_mul_result),
    .i_div_signed(i_div_signed), .i_div_numerator(i_div_numerator),
    .i_div_denominator(i_div_denominator),
    .o_div_result(o_div_result), .o_div_remainder(o_div_remainder)
  );

  typedef struct { int due; logic [63:0] val; } exp_t;
  exp_t mq[$];
  exp_t dq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] model_div(input logic s, input logic [31:0] n, input logic [31:0] d);
    int sn, sd, q, r;
    if (d == 0) return {32'hFFFF_FFFF, n};
    if (s) begin
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sn = n; sd = d;
      q = sn / sd; r = sn % sd;
      return {32'(q), 32'(r)};
    end
    return {n / d, n % d};
  endfunction

  // Advance one clock, sample 1 time unit later and retire anything due now.
  task automatic tick();
    exp_t e;
    @(posedge i_clock);
    cyc++;
    #1;
    while (mq.size() > 0 && mq[0].due <= cyc) begin
      e = mq.pop_front();
      chk("mul", o_mul_result, e.val);
    end
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      e = dq.pop_front();
      chk("div", {o_div_result, o_div_remainder}, e.val);
    end
  endtask

  task automatic issue_mul(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    i_mul_signed = s; i_mul_op1 = a; i_mul_op2 = b;
    mq.push_back('{cyc + 2, exp});
  endtask

  task automatic issue_div(input logic s, input logic [31:0] n, input logic [31:0] d,
                           input logic [31:0] q, input logic [31:0] r);
    i_div_signed = s; i_div_numerator = n; i_div_denominator = d;
    dq.push_back('{cyc + 3, {q, r}});
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ec);
    i_alu_op = op; i_alu_op1 = a; i_alu_op2 = b;
    #1;
    chk({tag, "_res"}, {32'b0, o_alu_result}, {32'b0, er});
    chk({tag, "_cmp"}, {63'b0, o_alu_compare}, {63'b0, ec});
  endtask

  task automatic rand_issue();
    logic s;
    logic [31:0] a, b, n, d;
    logic [63:0] dv;
    s = 1'($urandom_range(0, 1));
    a = $urandom; b = $urandom; n = $urandom;
    d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    issue_mul(s, a, b, model_mul(s, a, b));
    dv = model_div(s, n, d);
    issue_div(s, n, d, dv[63:32], dv[31:0]);
  endtask

  initial begin
    logic [63:0] dv;
    i_reset = 1'b1;
    i_alu_op = '0; i_alu_op1 = '0; i_alu_op2 = '0;
    i_mul_signed = 1'b0; i_mul_op1 = 32'h1234_5678; i_mul_op2 = 32'h9;
    i_div_signed = 1'b0; i_div_numerator = 32'h77; i_div_denominator = 32'h3;
    tick(); tick();
    chk("rst_mul", o_mul_result, 64'h0);
    chk("rst_div_q", {32'b0, o_div_result}, 64'h0);
    chk("rst_div_r", {32'b0, o_div_remainder}, 64'h0);
    i_reset = 1'b0;

    // ALU sweep
    alu("add",  4'd0,  32'hFFFF_FFF0, 32'h14, 32'h0000_0004, 1'b0);
    alu("sub",  4'd1,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFDC, 1'b0);
    alu("and",  4'd2,  32'hFFFF_FFF0, 32'h14, 32'h0000_0010, 1'b0);
    alu("or",   4'd3,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFF4, 1'b0);
    alu("xor",  4'd4,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFE4, 1'b0);
    alu("sll",  4'd5,  32'hFFFF_FFF0, 32'h14, 32'hFF00_0000, 1'b0);
    alu("srl",  4'd6,  32'hFFFF_FFF0, 32'h14, 32'h0000_0FFF, 1'b0);
    alu("sra",  4'd7,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFFF, 1'b0);
    alu("sra2", 4'd7,  32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 1'b0);
    alu("eq",   4'd8,  32'hFFFF_FFF0, 32'h14, 32'h0, 1'b0);
    alu("eq2",  4'd8,  32'h5, 32'h5, 32'h1, 1'b1);
    alu("ne",   4'd9,  32'hFFFF_FFF0, 32'h14, 32'h1, 1'b1);
    alu("lt",   4'd10, 32'hFFFF_FFF0, 32'h14, 32'h1, 1'b1);
    alu("ltu",  4'd11, 32'hFFFF_FFF0, 32'h14, 32'h0, 1'b0);
    alu("ge",   4'd12, 32'hFFFF_FFF0, 32'h14, 32'h0, 1'b0);
    alu("geu",  4'd13, 32'hFFFF_FFF0, 32'h14, 32'h1, 1'b1);
    alu("op14", 4'd14, 32'hFFFF_FFF0, 32'h14, 32'h0, 1'b0);
    alu("op15", 4'd15, 32'hFFFF_FFF0, 32'h14, 32'h0, 1'b0);

    // Multiply latency
    issue_mul(1'b1, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();
    issue_mul(1'b0, 32'hFFFF_FFFE, 32'h3, 64'h0000_0002_FFFF_FFFA);
    tick(); tick(); tick();

    // Divide cases and corners
    issue_div(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF); tick();
    issue_div(1'b0, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 32'h1);         tick();
    issue_div(1'b0, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5);                 tick();
    issue_div(1'b1, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB); tick();
    issue_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0); tick();
    issue_div(1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);         tick();
    repeat (4) tick();

    // Back-to-back issue, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      rand_issue();
      tick();
    end
    i_reset = 1'b1;
    mq.delete(); dq.delete();
    tick();
    chk("rst2_mul", o_mul_result, 64'h0);
    chk("rst2_div", {o_div_result, o_div_remainder}, 64'h0);
    i_reset = 1'b0;
    issue_mul(1'b0, 32'h10, 32'h20, 64'h200);
    dv = model_div(1'b1, 32'hFFFF_FF9C, 32'h7);
    issue_div(1'b1, 32'hFFFF_FF9C, 32'h7, dv[63:32], dv[31:0]);
    tick();
    chk("post_rst_mul", o_mul_result, 64'h0);
    chk("post_rst_div1", {o_div_result, o_div_remainder}, 64'h0);
    tick();
    chk("post_rst_div2", {o_div_result, o_div_remainder}, 64'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      rand_issue();
      tick();
    end
    repeat (5) tick();
    chk("drain_mul", 64'(mq.size()), 64'h0);
    chk("drain_div", 64'(dq.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
